uart_tx: RTL and testbench
==========================

# uart_tx

Serializing transmit stage of the UART: accepts parallel words from an upstream producer over a valid/ready handshake and shifts them out on `TX` as asynchronous serial frames. Frame format is start bit, data LSB first, optional parity, and one or two stop bits. Bit timing comes from a runtime clock divisor, and transmission is gated by `CTS`. It is the transmit counterpart of `uart_rx` and sits between the host/packet logic and the `TX` pin.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5–9 legal)
- `clk` input 1: single clock, all logic on rising edge
- `reset` input 1: synchronous, active-low (0 = reset asserted)
- `data_i` input DATA_WIDTH: word to transmit
- `data_valid_i` input 1: `data_i` is valid
- `data_ready_o` output 1: block can accept a word this cycle
- `baud_rate` input 20: clock cycles per bit cell, N; 0 is treated as 1
- `parity_en` input 1: insert parity bit after data
- `parity_odd` input 1: 1 = odd parity, 0 = even
- `stop2` input 1: 1 = two stop bits, 0 = one
- `CTS` input 1: 1 = receiver clear to send
- `TX` output 1: serial line, idles high
- `busy_o` output 1: frame in progress
- `tx_done_o` output 1: one-cycle pulse at the end of each frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `data_ready_o` = (state==IDLE) & `CTS` & `reset`. It is combinational, and 0 whenever reset is asserted.
- Accept: on an edge where `data_valid_i` & `data_ready_o` are both 1, latch the following into a shift register / config registers, then go to START:
  - `data_i`
  - `baud_rate`
  - `parity_en`, `parity_odd`, `stop2`
- Config and data inputs are ignored mid-frame. Changes take effect at the next accept.
- START: `TX`=0 for N cycles → DATA.
- DATA: `TX` = current LSB. Shift right every N cycles. After DATA_WIDTH bits → PARITY if the latched `parity_en`, else STOP.
- PARITY: `TX` = XOR(data) ^ `parity_odd` for N cycles → STOP.
- STOP: `TX`=1 for N cycles (2N if `stop2`) → IDLE.
  - `tx_done_o`=1 in the last cycle of STOP.
- Bit counter: ceil(log2(DATA_WIDTH+1)) bits. Baud counter: 20 bits, counts 0..N-1, no wrap beyond N-1.
- `CTS` is sampled only at accept. Deasserting it mid-frame does not abort the frame; the next accept waits for `CTS`=1.
- `busy_o` = (state != IDLE).
- `TX`, `busy_o`, and `tx_done_o` are registered.

## Timing
- Reset values: `TX`=1, `busy_o`=0, `tx_done_o`=0, `data_ready_o`=0, state=IDLE, counters=0.
- Reset asserted mid-frame: on the next edge `TX`=1 and state=IDLE. The frame is lost with no `tx_done_o` pulse.
- Accept at edge k: `TX` goes 0 after edge k.
  - Bit cell j (start = 0) occupies cycles k+1+jN … k+(j+1)N.
- Frame length F = N·(1 + DATA_WIDTH + P + S) cycles, where P = `parity_en`, S = 1 + `stop2`.
- `tx_done_o` is high in cycle k+F. `busy_o` is high for cycles k+1 … k+F.
- Next accept can occur at edge k+F+1 at the earliest, so back-to-back frames are separated by exactly one extra idle-high clock.
- `data_valid_i` held with `data_ready_o`=0: the word must be held stable. There is no drop and no duplicate accept.
- N=1: every bit is one clock. Frame length is still given by F.

## Test plan
- DATA_WIDTH=8, N=4, no parity, one stop, `data_i`=0xA5 → `TX` = 0,1,0,1,0,0,1,0,1,1. Each level lasts 4 cycles (40 total), `tx_done_o` pulses at cycle 40 after accept, and `busy_o` is high for 40 cycles.
- Parity on 0xA5 (four 1s), N=2, even then odd → parity cell `TX`=0 then `TX`=1. Frame is 22 cycles.
- `stop2`=1, N=3, `data_i`=0x00 → 9 low cells (27 cycles) followed by 6 high cycles. Two words with `data_valid_i` held continuously → exactly one idle-high clock between frames, and both words are transmitted in order.
- `CTS`=0 with `data_valid_i`=1 for 50 cycles → `data_ready_o`=0 and `TX`=1 throughout. `CTS` rises → accept on that edge.
- Drop `CTS` mid-frame → frame completes unchanged, and the next word is not accepted until `CTS`=1. Change `baud_rate` mid-frame → current frame keeps its old N.
- Assert `reset`=0 during DATA bit 3 → `TX`=1 and `busy_o`=0 on the next edge, no `tx_done_o`, and `data_ready_o`=0 while in reset. Release reset → new 0x3C frame is transmitted correctly. Also check `baud_rate`=0 → behaves as N=1.

Source files
------------

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : UART transmit serializer (start, LSB-first data, parity, stop)
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [19:0]           baud_rate,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  CTS,
  output logic                  TX,
  output logic                  busy_o,
  output logic                  tx_done_o
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [19:0]           baud_cnt_q, baud_cnt_d;
  logic [19:0]           n_q, n_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_en_q, parity_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cell_end;
  logic                  accept;

  assign data_ready_o = (state_q == IDLE) & CTS & reset;
  assign accept       = data_valid_i & data_ready_o;
  assign cell_end     = (baud_cnt_q == n_q - 20'd1);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    n_d         = n_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_en_d = parity_en_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;

    if (state_q != IDLE) begin
      baud_cnt_d = cell_end ? 20'd0 : baud_cnt_q + 20'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = START;
          baud_cnt_d  = 20'd0;
          bit_cnt_d   = '0;
          shift_d     = data_i;
          n_d         = (baud_rate == 20'd0) ? 20'd1 : baud_rate;
          parity_en_d = parity_en;
          stop2_d     = stop2;
          par_bit_d   = (^data_i) ^ parity_odd;
        end
      end
      START: begin
        if (cell_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (cell_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            state_d   = parity_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cell_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        // bit_cnt indexes the stop cell; the frame ends after cell 0 or 1
        if (cell_end) begin
          if (bit_cnt_q == BW'(stop2_q)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_cnt_d == n_d - 20'd1) &&
             (bit_cnt_d == BW'(stop2_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_cnt_q  <= 20'd0;
      n_q         <= 20'd1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_en_q <= 1'b0;
      stop2_q     <= 1'b0;
      par_bit_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      n_q         <= n_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_en_q <= parity_en_d;
      stop2_q     <= stop2_d;
      par_bit_q   <= par_bit_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign TX        = tx_q;
  assign busy_o    = busy_q;
  assign tx_done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : directed + random frames checked against a cell-list UART model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [19:0] baud_rate;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        CTS;
  logic        TX;
  logic        busy_o;
  logic        tx_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [19:0] baud;
    logic        pe;
    logic        po;
    logic        s2;
  } cfg_t;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .baud_rate    (baud_rate),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop2        (stop2),
    .CTS          (CTS),
    .TX           (TX),
    .busy_o       (busy_o),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk = ~clk;

  function automatic cfg_t mk(input int baud, input bit pe, input bit po, input bit s2);
    cfg_t c;
    c.baud = 20'(baud);
    c.pe   = pe;
    c.po   = po;
    c.s2   = s2;
    return c;
  endfunction

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    baud_rate  = c.baud;
    parity_en  = c.pe;
    parity_odd = c.po;
    stop2      = c.s2;
  endtask

  // Called at a negedge with the block idle; returns right after the accept edge.
  task automatic launch(input logic [7:0] w, input cfg_t c);
    data_i       = w;
    apply_cfg(c);
    CTS          = 1'b1;
    data_valid_i = 1'b1;
    #1 chk("ready_before_accept", 0, data_ready_o, 1'b1);
    @(posedge clk);
  endtask

  // Reference: a frame is a list of line levels, one per bit cell, each N clocks long.
  task automatic expect_frame(input logic [7:0] w, input cfg_t c, input int abort_at,
                              input bit drop_cts, input bit has_next,
                              input logic [7:0] nw, input cfg_t nc);
    int  n;
    int  cells;
    int  f;
    bit  lv [16];
    n = (c.baud == 20'd0) ? 1 : int'(c.baud);
    cells = 0;
    lv[cells++] = 1'b0;
    for (int i = 0; i < 8; i++) lv[cells++] = w[i];
    if (c.pe) lv[cells++] = (($countones(w) % 2) == 1) ? ~c.po : c.po;
    lv[cells++] = 1'b1;
    if (c.s2) lv[cells++] = 1'b1;
    f = n * cells;
    for (int t = 1; t <= f; t++) begin
      @(negedge clk);
      chk("tx_level", t, TX, lv[(t - 1) / n]);
      chk("busy_in_frame", t, busy_o, 1'b1);
      chk("done_pulse", t, tx_done_o, (t == f));
      chk("ready_in_frame", t, data_ready_o, 1'b0);
      if (t == 1) begin
        // Scramble config mid-frame: the running frame must not notice.
        baud_rate  = 20'($urandom_range(0, 7));
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        stop2      = 1'($urandom);
        if (has_next) begin
          data_i       = nw;
          data_valid_i = 1'b1;
        end else begin
          data_i       = 8'($urandom);
          data_valid_i = 1'b0;
        end
        if (drop_cts) CTS = 1'b0;
      end
      if (t == abort_at) begin
        reset = 1'b0;
        return;
      end
      if (t == f && has_next) apply_cfg(nc);
    end
    @(negedge clk);
    chk("idle_tx", f + 1, TX, 1'b1);
    chk("idle_busy", f + 1, busy_o, 1'b0);
    chk("idle_done", f + 1, tx_done_o, 1'b0);
    chk("idle_ready", f + 1, data_ready_o, CTS);
    if (has_next) @(posedge clk);
  endtask

  initial begin
    cfg_t c0;
    cfg_t c1;
    logic [7:0] w;
    c0 = mk(4, 0, 0, 0);

    reset        = 1'b0;
    CTS          = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 8'hA5;
    apply_cfg(c0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 0, TX, 1'b1);
      chk("rst_busy", 0, busy_o, 1'b0);
      chk("rst_done", 0, tx_done_o, 1'b0);
      chk("rst_ready", 0, data_ready_o, 1'b0);
    end
    data_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 0, data_ready_o, 1'b1);
    chk("post_rst_tx", 0, TX, 1'b1);

    // 0xA5, N=4, 8N1
    launch(8'hA5, c0);
    expect_frame(8'hA5, c0, 0, 0, 0, 8'h00, c0);

    // parity even then odd, N=2, back-to-back
    c0 = mk(2, 1, 0, 0);
    c1 = mk(2, 1, 1, 0);
    launch(8'hA5, c0);
    expect_frame(8'hA5, c0, 0, 0, 1, 8'hA5, c1);
    expect_frame(8'hA5, c1, 0, 0, 0, 8'h00, c1);

    // two stop bits, N=3, words streamed with valid held
    c0 = mk(3, 0, 0, 1);
    launch(8'h00, c0);
    expect_frame(8'h00, c0, 0, 0, 1, 8'h5A, c0);
    expect_frame(8'h5A, c0, 0, 0, 0, 8'h00, c0);

    // CTS low blocks acceptance
    c0 = mk(2, 0, 0, 0);
    apply_cfg(c0);
    data_i       = 8'hC3;
    data_valid_i = 1'b1;
    CTS          = 1'b0;
    repeat (50) begin
      @(negedge clk);
      chk("cts_block_ready", 0, data_ready_o, 1'b0);
      chk("cts_block_tx", 0, TX, 1'b1);
      chk("cts_block_busy", 0, busy_o, 1'b0);
    end
    launch(8'hC3, c0);
    expect_frame(8'hC3, c0, 0, 0, 0, 8'h00, c0);

    // CTS dropped mid-frame: frame completes, next word waits
    c0 = mk(3, 1, 1, 0);
    launch(8'h96, c0);
    expect_frame(8'h96, c0, 0, 1, 0, 8'h00, c0);
    data_i       = 8'h3C;
    data_valid_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("cts_wait_ready", 0, data_ready_o, 1'b0);
      chk("cts_wait_tx", 0, TX, 1'b1);
      chk("cts_wait_busy", 0, busy_o, 1'b0);
    end
    launch(8'h3C, c0);
    expect_frame(8'h3C, c0, 0, 0, 0, 8'h00, c0);

    // reset during data bit 3 (cell 4 = cycles 9..10 at N=2)
    c0 = mk(2, 0, 0, 0);
    launch(8'hF0, c0);
    expect_frame(8'hF0, c0, 9, 0, 0, 8'h00, c0);
    data_valid_i = 1'b1;
    data_i       = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      chk("abort_tx", 0, TX, 1'b1);
      chk("abort_busy", 0, busy_o, 1'b0);
      chk("abort_done", 0, tx_done_o, 1'b0);
      chk("abort_ready", 0, data_ready_o, 1'b0);
    end
    reset = 1'b1;
    launch(8'h3C, c0);
    expect_frame(8'h3C, c0, 0, 0, 0, 8'h00, c0);

    // baud_rate 0 behaves as N=1
    c0 = mk(0, 1, 0, 1);
    launch(8'h6B, c0);
    expect_frame(8'h6B, c0, 0, 0, 0, 8'h00, c0);

    // random frames
    for (int i = 0; i < 8; i++) begin
      w  = 8'($urandom);
      c0 = mk($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom));
      launch(w, c0);
      expect_frame(w, c0, 0, 0, 0, 8'h00, c0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
